// File: rtl/imm_pkg.sv
// Shared constants for the immediate decode pipeline: RISC-V opcodes,
// shift funct3 codes and the immediate format encoding.
package imm_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Srx = 3'b101;

  typedef enum logic [2:0] {
    FmtNone  = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShamt = 3'd6,
    FmtCsrz  = 3'd7
  } imm_fmt_e;

  function automatic logic is_shift(logic [2:0] funct3);
    return (funct3 == F3Sll) || (funct3 == F3Srx);
  endfunction

endpackage

// File: rtl/imm_fifo.sv
// Circular output buffer for decoded entries. No full-bypass: a push is refused
// while full even if the head pops in the same cycle. Head reads as zero when empty.
module imm_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        wr_d = ptr_inc(wr_q);
      end
      if (pop_ok) begin
        rd_d = ptr_inc(rd_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Decodes the immediate, format and branch/jump target of an incoming
// instruction and queues the result in a small output buffer.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic             out_target_valid,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  if (!((XLEN == 32) || (XLEN == 64))) begin : gen_bad_xlen
    $error("imm_decode_pipe: XLEN must be 32 or 64");
  end
  if ((DEPTH < 1) || (DEPTH > 8)) begin : gen_bad_depth
    $error("imm_decode_pipe: DEPTH must be 1..8");
  end

  localparam int unsigned EntW = 2 * XLEN + 5;

  logic [6:0]       opc;
  logic [2:0]       funct3;
  imm_fmt_e         dec_fmt;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  dec_target;
  logic             dec_tv;
  logic             dec_ill;
  logic [EntW-1:0]  enq_data, deq_data;
  logic             fifo_full, fifo_empty;
  logic             accept, pop;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    dec_fmt = FmtNone;
    dec_imm = '0;
    dec_tv  = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OpcOpImm: begin
        if (is_shift(funct3)) begin
          dec_fmt = FmtShamt;
          if (XLEN == 64) begin
            dec_imm = XLEN'(inst[25:20]);
          end else begin
            dec_imm = XLEN'(inst[24:20]);
            dec_ill = inst[25];
          end
        end else begin
          dec_fmt = FmtI;
          dec_imm = XLEN'(signed'(inst[31:20]));
        end
      end
      OpcLoad, OpcJalr: begin
        dec_fmt = FmtI;
        dec_imm = XLEN'(signed'(inst[31:20]));
      end
      OpcStore: begin
        dec_fmt = FmtS;
        dec_imm = XLEN'(signed'({inst[31:25], inst[11:7]}));
      end
      OpcBranch: begin
        dec_fmt = FmtB;
        dec_imm = XLEN'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        dec_tv  = 1'b1;
      end
      OpcLui: begin
        dec_fmt = FmtU;
        dec_imm = XLEN'(signed'({inst[31:12], 12'b0}));
      end
      OpcAuipc: begin
        dec_fmt = FmtU;
        dec_imm = XLEN'(signed'({inst[31:12], 12'b0}));
        dec_tv  = 1'b1;
      end
      OpcJal: begin
        dec_fmt = FmtJ;
        dec_imm = XLEN'(signed'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        dec_tv  = 1'b1;
      end
      OpcSystem: begin
        // CSR immediate forms carry a 5-bit uimm in the rs1 field.
        if (funct3[2]) begin
          dec_fmt = FmtCsrz;
          dec_imm = XLEN'(inst[19:15]);
        end
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_target = dec_tv ? (pc + dec_imm) : '0;

  assign in_ready  = reset_n && !fifo_full && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign enq_data = {dec_ill, dec_tv, dec_fmt, dec_target, dec_imm};
  assign {out_illegal, out_target_valid, out_fmt, out_target, out_imm} = deq_data;

  imm_fifo #(
    .Width(EntW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .flush_i(flush),
    .push_i (accept),
    .data_i (enq_data),
    .pop_i  (pop),
    .data_o (deq_data),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (accept && dec_ill && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  // Deliberately not cleared by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign illegal_count = ill_cnt_q;

endmodule
